// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer handshake and CDB broadcast bundle for cdb_arbiter.
//   slave  : arbiter side (takes requests, drives ready and the CDB)
//   master : producer/consumer side (drives requests, observes ready and the CDB)
// i_req_rob_id / i_req_value are flat; producer i owns slice [i*W +: W].
interface cdb_arbiter_if #(
  parameter int N_REQ    = 3,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32,
  parameter int SRC_W    = 2
);
  logic [N_REQ-1:0]          i_req_valid;
  logic [N_REQ*ROB_ID_W-1:0] i_req_rob_id;
  logic [N_REQ*DATA_W-1:0]   i_req_value;
  logic [N_REQ-1:0]          o_req_ready;
  logic                      o_cdb_valid;
  logic [ROB_ID_W-1:0]       o_cdb_rob_id;
  logic [DATA_W-1:0]         o_cdb_value;
  logic [SRC_W-1:0]          o_cdb_src;

  modport slave (
    input  i_req_valid, i_req_rob_id, i_req_value,
    output o_req_ready, o_cdb_valid, o_cdb_rob_id, o_cdb_value, o_cdb_src
  );

  modport master (
    output i_req_valid, i_req_rob_id, i_req_value,
    input  o_req_ready, o_cdb_valid, o_cdb_rob_id, o_cdb_value, o_cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Each producer (0 = ALU, 1 = LSB, 2 = branch) hands a result into its own
// one-entry buffer; one full buffer per cycle is granted and broadcast
// through a registered CDB.
//   clk_in  : clock
//   rst_in  : synchronous reset, active low (beats rdy_in and i_clear)
//   rdy_in  : global ready, low freezes every register and drops req_ready
//   i_clear : flush, empties all buffers and suppresses this cycle's broadcast
//   bus     : request handshake + CDB outputs (cdb_arbiter_if.slave)

// cdb_buf: one producer's holding buffer.
//   i_grant : this buffer wins the CDB this cycle (drained at the edge)
//   o_ready : buffer accepts this cycle; a drained buffer may refill at once
module cdb_buf #(
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic [ROB_ID_W-1:0] i_tag,
  input  logic [DATA_W-1:0]   i_val,
  input  logic                i_grant,
  output logic                o_ready,
  output logic                o_full,
  output logic [ROB_ID_W-1:0] o_tag,
  output logic [DATA_W-1:0]   o_val
);
  logic                r_full;
  logic [ROB_ID_W-1:0] r_tag;
  logic [DATA_W-1:0]   r_val;
  logic                w_ready;

  assign w_ready = rdy_in & ~i_clear & (~r_full | i_grant);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_full <= 1'b0;
      r_tag  <= '0;
      r_val  <= '0;
    end else if (rdy_in) begin
      if (i_clear) begin
        r_full <= 1'b0;
      end else if (i_valid && w_ready) begin
        // refill has priority over drain so a granted buffer stays full
        r_full <= 1'b1;
        r_tag  <= i_tag;
        r_val  <= i_val;
      end else if (i_grant) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_ready = w_ready;
  assign o_full  = r_full;
  assign o_tag   = r_tag;
  assign o_val   = r_val;
endmodule

module cdb_arbiter #(
  parameter int N_REQ    = 3,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32,
  parameter int SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         i_clear,
  cdb_arbiter_if.slave bus
);
  logic [N_REQ-1:0]               w_full;
  logic [N_REQ-1:0][ROB_ID_W-1:0] w_tag;
  logic [N_REQ-1:0][DATA_W-1:0]   w_val;
  logic [N_REQ-1:0]               w_grant;
  logic                           w_gnt_any;
  logic [SRC_W-1:0]               w_gnt_idx;

  logic [SRC_W-1:0]               r_last;
  logic                           r_cdb_valid;
  logic [ROB_ID_W-1:0]            r_cdb_rob_id;
  logic [DATA_W-1:0]              r_cdb_value;
  logic [SRC_W-1:0]               r_cdb_src;

  for (genvar g = 0; g < N_REQ; g++) begin : g_buf
    cdb_buf #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_buf (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .rdy_in  (rdy_in),
      .i_clear (i_clear),
      .i_valid (bus.i_req_valid[g]),
      .i_tag   (bus.i_req_rob_id[g*ROB_ID_W +: ROB_ID_W]),
      .i_val   (bus.i_req_value[g*DATA_W +: DATA_W]),
      .i_grant (w_grant[g]),
      .o_ready (bus.o_req_ready[g]),
      .o_full  (w_full[g]),
      .o_tag   (w_tag[g]),
      .o_val   (w_val[g])
    );
  end

  // Search starts one past the last winner and wraps, so the last winner
  // has the lowest priority this cycle.
  always_comb begin
    int unsigned idx;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_last) + k) % N_REQ;
      if (!w_gnt_any && w_full[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = SRC_W'(idx);
      end
    end
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_last       <= SRC_W'(N_REQ - 1);
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= '0;
    end else if (rdy_in) begin
      if (i_clear) begin
        // flush drops this cycle's grant; pointer is kept
        r_cdb_valid <= 1'b0;
      end else if (w_gnt_any) begin
        r_last       <= w_gnt_idx;
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_id <= w_tag[w_gnt_idx];
        r_cdb_value  <= w_val[w_gnt_idx];
        r_cdb_src    <= w_gnt_idx;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign bus.o_cdb_valid  = r_cdb_valid;
  assign bus.o_cdb_rob_id = r_cdb_rob_id;
  assign bus.o_cdb_value  = r_cdb_value;
  assign bus.o_cdb_src    = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n, rdy, clr;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N), .ROB_ID_W(TW), .DATA_W(DW), .SRC_W(2)) bus ();

  cdb_arbiter #(.N_REQ(N), .ROB_ID_W(TW), .DATA_W(DW), .SRC_W(2)) dut (
    .clk_in  (clk),
    .rst_in  (rst_n),
    .rdy_in  (rdy),
    .i_clear (clr),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // current stimulus
  logic [N-1:0]  s_valid;
  logic [TW-1:0] s_tag [N];
  logic [DW-1:0] s_val [N];
  logic [N-1:0]  s_acc;      // accepted at the last edge (from the model)

  // reference model: buffer contents, round-robin pointer, CDB
  bit            m_init = 0;
  bit            m_full [N];
  logic [TW-1:0] m_tag  [N];
  logic [DW-1:0] m_val  [N];
  int            m_last;
  bit            m_cv;
  logic [TW-1:0] m_ctag;
  logic [DW-1:0] m_cval;
  int            m_csrc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // first full buffer in rotation order after the last winner, -1 if none
  function automatic int m_winner();
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (m_full[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g = m_winner();
    for (int i = 0; i < N; i++)
      r[i] = rdy && !clr && (!m_full[i] || i == g);
    return r;
  endfunction

  task automatic m_edge(input logic [N-1:0] rd);
    s_acc = '0;
    if (!rst_n) begin
      m_init = 1;
      for (int i = 0; i < N; i++) begin m_full[i] = 0; m_tag[i] = '0; m_val[i] = '0; end
      m_last = N - 1; m_cv = 0; m_ctag = '0; m_cval = '0; m_csrc = 0;
    end else if (rdy) begin
      if (clr) begin
        for (int i = 0; i < N; i++) m_full[i] = 0;
        m_cv = 0;
      end else begin
        int g = m_winner();
        if (g >= 0) begin
          m_cv = 1; m_ctag = m_tag[g]; m_cval = m_val[g]; m_csrc = g; m_last = g;
        end else begin
          m_cv = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (s_valid[i] && rd[i]) begin
            m_full[i] = 1; m_tag[i] = s_tag[i]; m_val[i] = s_val[i]; s_acc[i] = 1'b1;
          end else if (i == g) begin
            m_full[i] = 0;
          end
        end
      end
    end
  endtask

  // one clock: drive, check ready mid-cycle, clock, check CDB against model
  task automatic step(output logic [N-1:0] rs);
    logic [N-1:0] er;
    bus.i_req_valid = s_valid;
    for (int i = 0; i < N; i++) begin
      bus.i_req_rob_id[i*TW +: TW] = s_tag[i];
      bus.i_req_value[i*DW +: DW]  = s_val[i];
    end
    @(negedge clk);
    rs = bus.o_req_ready;
    er = m_ready();
    if (m_init) chk("model_ready", rs, er);
    @(posedge clk);
    m_edge(er);
    #1;
    chk("model_cdb_valid", bus.o_cdb_valid, m_cv);
    chk("model_cdb_tag", bus.o_cdb_rob_id, m_ctag);
    chk("model_cdb_value", bus.o_cdb_value, m_cval);
    if (m_cv) chk("model_cdb_src", bus.o_cdb_src, m_csrc);
  endtask

  task automatic set_req(input logic [N-1:0] v, input logic [TW-1:0] t0, t1, t2,
                         input logic [DW-1:0] d0, d1, d2);
    s_valid = v;
    s_tag[0] = t0; s_tag[1] = t1; s_tag[2] = t2;
    s_val[0] = d0; s_val[1] = d1; s_val[2] = d2;
  endtask

  task automatic exp_cdb(input string name, input bit cv, input logic [TW-1:0] t, input int src);
    chk({name, "_valid"}, bus.o_cdb_valid, cv);
    chk({name, "_tag"}, bus.o_cdb_rob_id, t);
    if (cv) chk({name, "_src"}, bus.o_cdb_src, src);
  endtask

  typedef struct {
    bit rst_n, rdy, clr;
    logic [2:0] v;
    logic [TW-1:0] t0, t1, t2;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0] e_rdy;
    bit e_cv;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_val;
    int e_src;
  } vec_t;

  vec_t tbl[$];
  logic [N-1:0] rs;
  int cnt [N];

  initial begin
    // single ALU request: 2 cycles valid->broadcast
    tbl.push_back('{1,1,0,3'b001, 5,0,0, 32'h1234,0,0, 3'b111, 0, 0, 0, 0});
    tbl.push_back('{1,1,0,3'b000, 0,0,0, 0,0,0,       3'b111, 1, 5, 32'h1234, 0});
    tbl.push_back('{1,1,0,3'b000, 0,0,0, 0,0,0,       3'b111, 0, 5, 32'h1234, 0});
    // reset, then three simultaneous requests broadcast as 0,1,2
    tbl.push_back('{0,1,0,3'b000, 0,0,0, 0,0,0,       3'b111, 0, 0, 0, 0});
    tbl.push_back('{1,1,0,3'b111, 1,2,3, 32'h11,32'h22,32'h33, 3'b111, 0, 0, 0, 0});
    tbl.push_back('{1,1,0,3'b000, 0,0,0, 0,0,0,       3'b001, 1, 1, 32'h11, 0});
    tbl.push_back('{1,1,0,3'b000, 0,0,0, 0,0,0,       3'b011, 1, 2, 32'h22, 1});
    tbl.push_back('{1,1,0,3'b000, 0,0,0, 0,0,0,       3'b111, 1, 3, 32'h33, 2});
    tbl.push_back('{1,1,0,3'b000, 0,0,0, 0,0,0,       3'b111, 0, 3, 32'h33, 0});
    // backpressure: producer 1 holds tag 31 until its full buffer is granted
    tbl.push_back('{0,1,0,3'b000, 0,0,0, 0,0,0,       3'b111, 0, 0, 0, 0});
    tbl.push_back('{1,1,0,3'b111, 20,21,22, 32'h20,32'h21,32'h22, 3'b111, 0, 0, 0, 0});
    tbl.push_back('{1,1,0,3'b111, 20,31,22, 32'h20,32'h31,32'h22, 3'b001, 1, 20, 32'h20, 0});
    tbl.push_back('{1,1,0,3'b111, 20,31,22, 32'h20,32'h31,32'h22, 3'b010, 1, 21, 32'h21, 1});
    tbl.push_back('{1,1,0,3'b101, 20,0,22, 32'h20,0,32'h22,       3'b100, 1, 22, 32'h22, 2});
    tbl.push_back('{1,1,0,3'b101, 20,0,22, 32'h20,0,32'h22,       3'b001, 1, 20, 32'h20, 0});
    tbl.push_back('{1,1,0,3'b101, 20,0,22, 32'h20,0,32'h22,       3'b010, 1, 31, 32'h31, 1});

    rst_n = 0; rdy = 1; clr = 0;
    set_req(3'b000, 0, 0, 0, 0, 0, 0);
    step(rs); step(rs);
    exp_cdb("reset", 0, 0, 0);
    chk("reset_value", bus.o_cdb_value, 0);
    rst_n = 1;

    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n; rdy = tbl[k].rdy; clr = tbl[k].clr;
      set_req(tbl[k].v, tbl[k].t0, tbl[k].t1, tbl[k].t2, tbl[k].d0, tbl[k].d1, tbl[k].d2);
      step(rs);
      chk($sformatf("tbl%0d_ready", k), rs, tbl[k].e_rdy);
      exp_cdb($sformatf("tbl%0d_cdb", k), tbl[k].e_cv, tbl[k].e_tag, 0 + tbl[k].e_src);
      chk($sformatf("tbl%0d_value", k), bus.o_cdb_value, tbl[k].e_val);
    end
    rst_n = 1;

    // saturation: 12 broadcasts, src 0,1,2 repeating, 4 grants each
    rst_n = 0; set_req(3'b000, 0, 0, 0, 0, 0, 0); step(rs); rst_n = 1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 1; c <= 13; c++) begin
      set_req(3'b111, 8, 9, 10, 32'h100, 32'h101, 32'h102);
      step(rs);
      if (c >= 2) begin
        exp_cdb("sat", 1, TW'((c - 2) % 3 + 8), (c - 2) % 3);
        if (bus.o_cdb_src < N) cnt[bus.o_cdb_src]++;
      end
    end
    for (int i = 0; i < N; i++) chk($sformatf("sat_count%0d", i), cnt[i], 4);

    // flush with buffers 0 and 2 full; pointer must survive
    rst_n = 0; set_req(3'b000, 0, 0, 0, 0, 0, 0); step(rs); rst_n = 1;
    set_req(3'b101, 6, 0, 7, 32'h66, 0, 32'h77); step(rs);
    set_req(3'b000, 0, 0, 0, 0, 0, 0); clr = 1; step(rs); clr = 0;
    chk("flush_ready", rs, 3'b000);
    exp_cdb("flush", 0, 0, 0);
    for (int c = 0; c < 4; c++) begin step(rs); chk("flush_idle_valid", bus.o_cdb_valid, 0); end
    set_req(3'b011, 12, 13, 0, 32'hc, 32'hd, 0); step(rs);
    set_req(3'b000, 0, 0, 0, 0, 0, 0);
    step(rs); exp_cdb("post_flush0", 1, 12, 0);
    step(rs); exp_cdb("post_flush1", 1, 13, 1);

    // rdy low for 3 cycles with a grant pending
    rst_n = 0; step(rs); rst_n = 1;
    set_req(3'b011, 9, 10, 0, 32'h9, 32'ha, 0); step(rs);
    set_req(3'b000, 0, 0, 0, 0, 0, 0);
    step(rs); exp_cdb("pre_stall", 1, 9, 0);
    rdy = 0;
    for (int c = 0; c < 3; c++) begin
      step(rs);
      chk("stall_ready", rs, 3'b000);
      exp_cdb("stall", 1, 9, 0);
    end
    rdy = 1;
    step(rs); exp_cdb("resume", 1, 10, 1);
    step(rs); chk("resume_idle", bus.o_cdb_valid, 0);

    // reset while every buffer is full
    set_req(3'b111, 1, 2, 3, 32'h1, 32'h2, 32'h3); step(rs);
    set_req(3'b000, 0, 0, 0, 0, 0, 0);
    rst_n = 0; step(rs); rst_n = 1;
    exp_cdb("midrst", 0, 0, 0);
    chk("midrst_value", bus.o_cdb_value, 0);
    step(rs);
    chk("midrst_ready", rs, 3'b111);

    // random traffic against the model; a stalled request holds its data
    s_acc = '0;
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      clr   = ($urandom_range(0, 29) == 0);
      rdy   = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < N; i++) begin
        if (!(s_valid[i] && !s_acc[i])) begin
          s_valid[i] = ($urandom_range(0, 2) != 0);
          s_tag[i]   = TW'($urandom);
          s_val[i]   = $urandom;
        end
      end
      step(rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
